// File: rtl/timing_ir_flags.sv
// Sequence counter, instruction register and 1-bit flags feeding the control unit.
// Latency: state updates on the rising Clock; T/D/I/B are same-cycle decodes of SC/IR. No backpressure.
// Optional SINGLE_STEP_EN adds Step_Mode, which halts S at the end of every instruction.
module timing_ir_flags #(
    parameter int   SC_WIDTH   = 4,
    parameter int   WORD_WIDTH = 16,
    parameter logic S_RESET    = 1'b1
) (
    input  logic                      Clock,
    input  logic                      Reset_n,
    input  logic [WORD_WIDTH-1:0]     Bus_In,
    input  logic                      LD_IR,
    input  logic                      CLR_SC,
    input  logic                      INR_SC,
    input  logic                      Set_S,
    input  logic                      Clear_S,
    input  logic                      Clear_E,
    input  logic                      Comp_E,
    input  logic                      Load_E,
    input  logic                      E_In,
    input  logic                      Set_R,
    input  logic                      Clear_R,
    input  logic                      Set_IEN,
    input  logic                      Clear_IEN,
    input  logic                      In_Strobe,
    input  logic                      Clear_FGI,
    input  logic                      Set_FGO,
    input  logic                      Out_Start,
`ifdef SINGLE_STEP_EN
    input  logic                      Step_Mode,
`endif
    output logic [(2**SC_WIDTH)-1:0]  T,
    output logic [7:0]                D,
    output logic                      I,
    output logic [WORD_WIDTH-5:0]     B,
    output logic                      S,
    output logic                      R,
    output logic                      E,
    output logic                      IEN,
    output logic                      FGI,
    output logic                      FGO
);

    localparam int T_W = 2**SC_WIDTH;

    logic [SC_WIDTH-1:0]   sc;
    logic [WORD_WIDTH-1:0] ir;
    logic                  step_halt;

`ifdef SINGLE_STEP_EN
    // Ending an instruction while stepping drops S so the next fetch waits for Set_S.
    assign step_halt = Step_Mode & CLR_SC & S;
`else
    assign step_halt = 1'b0;
`endif

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            sc  <= '0;
            ir  <= '0;
            S   <= S_RESET;
            R   <= 1'b0;
            E   <= 1'b0;
            IEN <= 1'b0;
            FGI <= 1'b0;
            FGO <= 1'b1;
        end else begin
            if (CLR_SC)
                sc <= '0;
            else if (INR_SC && S)
                sc <= sc + SC_WIDTH'(1);

            if (LD_IR)
                ir <= Bus_In;

            if (Clear_S || step_halt)
                S <= 1'b0;
            else if (Set_S)
                S <= 1'b1;

            if (Clear_E)
                E <= 1'b0;
            else if (Load_E)
                E <= E_In;
            else if (Comp_E)
                E <= ~E;

            if (Clear_R)
                R <= 1'b0;
            else if (Set_R)
                R <= 1'b1;

            if (Clear_IEN)
                IEN <= 1'b0;
            else if (Set_IEN)
                IEN <= 1'b1;

            // A character arriving the same cycle INP consumes the previous one must not be lost.
            if (In_Strobe)
                FGI <= 1'b1;
            else if (Clear_FGI)
                FGI <= 1'b0;

            if (Set_FGO)
                FGO <= 1'b1;
            else if (Out_Start)
                FGO <= 1'b0;
        end
    end

    assign T = T_W'(1) << sc;
    assign D = 8'(1) << ir[WORD_WIDTH-2:WORD_WIDTH-4];
    assign I = ir[WORD_WIDTH-1];
    assign B = ir[WORD_WIDTH-5:0];

endmodule

// File: tb/tb_timing_ir_flags.sv
// Directed bench for timing_ir_flags: a per-cycle reference model plus hand-computed checkpoints.
module tb_timing_ir_flags;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic [15:0] Bus_In;
    logic LD_IR, CLR_SC, INR_SC, Set_S, Clear_S, Clear_E, Comp_E, Load_E, E_In;
    logic Set_R, Clear_R, Set_IEN, Clear_IEN, In_Strobe, Clear_FGI, Set_FGO, Out_Start;
`ifdef SINGLE_STEP_EN
    logic Step_Mode;
`endif
    logic [15:0] T;
    logic [7:0]  D;
    logic        I;
    logic [11:0] B;
    logic        S, R, E, IEN, FGI, FGO;

    int compared   = 0;
    int mismatched = 0;
    bit started    = 1'b0;

    // Reference state, kept as plain numbers
    int          m_sc;
    logic [15:0] m_ir;
    logic        m_s, m_r, m_e, m_ien, m_fgi, m_fgo;

    always #5 Clock = ~Clock;

    timing_ir_flags dut (
        .Clock(Clock), .Reset_n(Reset_n), .Bus_In(Bus_In), .LD_IR(LD_IR),
        .CLR_SC(CLR_SC), .INR_SC(INR_SC), .Set_S(Set_S), .Clear_S(Clear_S),
        .Clear_E(Clear_E), .Comp_E(Comp_E), .Load_E(Load_E), .E_In(E_In),
        .Set_R(Set_R), .Clear_R(Clear_R), .Set_IEN(Set_IEN), .Clear_IEN(Clear_IEN),
        .In_Strobe(In_Strobe), .Clear_FGI(Clear_FGI), .Set_FGO(Set_FGO), .Out_Start(Out_Start),
`ifdef SINGLE_STEP_EN
        .Step_Mode(Step_Mode),
`endif
        .T(T), .D(D), .I(I), .B(B), .S(S), .R(R), .E(E), .IEN(IEN), .FGI(FGI), .FGO(FGO)
    );

    function automatic bit step_stop();
`ifdef SINGLE_STEP_EN
        return Step_Mode && CLR_SC && m_s;
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            m_sc <= 0; m_ir <= 16'h0000; m_s <= 1'b1; m_r <= 1'b0;
            m_e <= 1'b0; m_ien <= 1'b0; m_fgi <= 1'b0; m_fgo <= 1'b1;
        end else begin
            m_sc  <= CLR_SC ? 0 : ((INR_SC && m_s) ? (m_sc + 1) % 16 : m_sc);
            m_ir  <= LD_IR ? Bus_In : m_ir;
            m_s   <= (Clear_S || step_stop()) ? 1'b0 : (Set_S ? 1'b1 : m_s);
            m_e   <= Clear_E ? 1'b0 : (Load_E ? E_In : (Comp_E ? !m_e : m_e));
            m_r   <= Clear_R ? 1'b0 : (Set_R ? 1'b1 : m_r);
            m_ien <= Clear_IEN ? 1'b0 : (Set_IEN ? 1'b1 : m_ien);
            m_fgi <= In_Strobe ? 1'b1 : (Clear_FGI ? 1'b0 : m_fgi);
            m_fgo <= Set_FGO ? 1'b1 : (Out_Start ? 1'b0 : m_fgo);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("model T", 32'(T), 32'(16'(1) << m_sc));
        chk("model D", 32'(D), 32'(8'(1) << m_ir[14:12]));
        chk("model I", 32'(I), 32'(m_ir[15]));
        chk("model B", 32'(B), 32'(m_ir[11:0]));
        chk("model S", 32'(S), 32'(m_s));
        chk("model R", 32'(R), 32'(m_r));
        chk("model E", 32'(E), 32'(m_e));
        chk("model IEN", 32'(IEN), 32'(m_ien));
        chk("model FGI", 32'(FGI), 32'(m_fgi));
        chk("model FGO", 32'(FGO), 32'(m_fgo));
    endtask

    task automatic idle();
        Bus_In = 16'h0000; LD_IR = 0; CLR_SC = 0; INR_SC = 0; Set_S = 0; Clear_S = 0;
        Clear_E = 0; Comp_E = 0; Load_E = 0; E_In = 0; Set_R = 0; Clear_R = 0;
        Set_IEN = 0; Clear_IEN = 0; In_Strobe = 0; Clear_FGI = 0; Set_FGO = 0; Out_Start = 0;
`ifdef SINGLE_STEP_EN
        Step_Mode = 0;
`endif
    endtask

    // Apply the currently driven strobes for one edge, then return them to idle.
    task automatic tick();
        @(posedge Clock);
        #1;
        idle();
    endtask

    initial begin
        idle();
        Reset_n = 1'b0;
        #12;
        Reset_n = 1'b1;
        started = 1'b1;
        fork
            forever begin
                @(negedge Clock);
                if (started) compare_model();
            end
        join_none

        chk("reset T", 32'(T), 32'h0001);
        chk("reset D", 32'(D), 32'h01);
        chk("reset S", 32'(S), 32'h1);
        chk("reset FGO", 32'(FGO), 32'h1);
        chk("reset E", 32'(E), 32'h0);

        // Walk SC through all 16 states and wrap
        for (int k = 1; k <= 17; k++) begin
            INR_SC = 1; tick();
            if (k == 15) chk("walk T15", 32'(T), 32'h8000);
        end
        chk("wrap T1", 32'(T), 32'h0002);
        Clear_S = 1; Set_S = 1; tick();
        chk("clear_s wins", 32'(S), 32'h0);
        INR_SC = 1; tick();
        INR_SC = 1; tick();
        chk("halt freezes T", 32'(T), 32'h0002);
        Set_S = 1; tick();

        Bus_In = 16'hB7C4; LD_IR = 1; tick();
        chk("ld_ir I", 32'(I), 32'h1);
        chk("ld_ir D", 32'(D), 32'h08);
        chk("ld_ir B", 32'(B), 32'h7C4);
        CLR_SC = 1; INR_SC = 1; tick();
        chk("clr over inr", 32'(T), 32'h0001);

        Comp_E = 1; tick();
        chk("comp_e", 32'(E), 32'h1);
        Comp_E = 1; Load_E = 1; E_In = 0; tick();
        chk("load over comp", 32'(E), 32'h0);
        Load_E = 1; E_In = 1; tick();
        chk("load_e 1", 32'(E), 32'h1);
        Clear_E = 1; Load_E = 1; E_In = 1; tick();
        chk("clear over load", 32'(E), 32'h0);

        In_Strobe = 1; Clear_FGI = 1; tick();
        chk("strobe over clr", 32'(FGI), 32'h1);
        Clear_FGI = 1; tick();
        chk("clear_fgi", 32'(FGI), 32'h0);
        Out_Start = 1; tick();
        chk("out_start", 32'(FGO), 32'h0);
        Set_FGO = 1; Out_Start = 1; tick();
        chk("set_fgo wins", 32'(FGO), 32'h1);

        Set_R = 1; Set_IEN = 1; tick();
        chk("set_r", 32'(R), 32'h1);
        Set_R = 1; Clear_R = 1; Set_IEN = 1; Clear_IEN = 1; tick();
        chk("clear_r wins", 32'(R), 32'h0);
        chk("clear_ien wins", 32'(IEN), 32'h0);

        // Async reset mid-count at SC=7, with the E/IEN flags set
        Bus_In = 16'h5A5A; LD_IR = 1; Set_IEN = 1; Comp_E = 1; In_Strobe = 1; Out_Start = 1; tick();
        CLR_SC = 1; tick();
        for (int k = 0; k < 7; k++) begin INR_SC = 1; tick(); end
        chk("count T7", 32'(T), 32'h0080);
        INR_SC = 1; Clear_S = 1; Set_R = 1;
        #2;
        Reset_n = 1'b0;
        #1;
        chk("async T", 32'(T), 32'h0001);
        chk("async D", 32'(D), 32'h01);
        chk("async S", 32'(S), 32'h1);
        chk("async FGO", 32'(FGO), 32'h1);
        chk("async flags", 32'({I, B, R, E, IEN, FGI}), 32'h0);
        Reset_n = 1'b1;
        idle();
        tick();

`ifdef SINGLE_STEP_EN
        for (int k = 0; k < 5; k++) begin INR_SC = 1; tick(); end
        chk("step T5", 32'(T), 32'h0020);
        Step_Mode = 1; CLR_SC = 1; Set_S = 1; tick();
        chk("step T0", 32'(T), 32'h0001);
        chk("step halts S", 32'(S), 32'h0);
        Step_Mode = 1; INR_SC = 1; tick();
        chk("step frozen", 32'(T), 32'h0001);
        Step_Mode = 1; Set_S = 1; tick();
        chk("step resume S", 32'(S), 32'h1);
        Step_Mode = 1; INR_SC = 1; tick();
        chk("step counts", 32'(T), 32'h0002);
`else
        Set_S = 1; CLR_SC = 1; tick();
        chk("no step S", 32'(S), 32'h1);
`endif
        tick();
        @(negedge Clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

endmodule
